seq_sm_multiplier: RTL

- Parametrised, multi-cycle sign-magnitude fixed-point multiplier. Successor to the 16-bit single-cycle multiply unit.
- Operand format: bit N-1 is the sign; bits N-2..0 are the magnitude, with FRAC fractional bits.
- Uses an iterative shift-add datapath with a start/busy/done handshake. Adds programmable fraction alignment, real overflow detection with optional saturation, and negative-zero suppression.
- Sits in the ALU/execution stage, alongside the existing arithmetic units.

---
 rtl/seq_sm_multiplier.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/seq_sm_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : seq_sm_multiplier
//  Purpose  : Iterative shift-add sign-magnitude fixed-point multiplier with a
//             start/busy/done handshake, fraction alignment, overflow
//             detection (optional saturation) and negative-zero suppression.
//  Revision : 1.0  initial release
// ============================================================================
module seq_sm_multiplier #(
   parameter int N    = 16,   // operand/result width including sign bit
   parameter int FRAC = 0,    // fractional bits removed from the full product
   parameter int SAT  = 1     // 1: saturate magnitude on overflow, 0: truncate
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] c,
   output logic         zero,
   output logic         neg,
   output logic         overflow,
   output logic         cout
);

   localparam int M  = N - 1;          // magnitude width
   localparam int W  = 2 * M;          // full product width
   localparam int CW = $clog2(N);      // counter width, holds M

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [W-1:0]  mcand_q;
   logic [W-1:0]  acc_q;
   logic [M-1:0]  mplier_q;
   logic [CW-1:0] cnt_q;
   logic          sign_q;

   logic [N-1:0]  c_q;
   logic          zero_q, ovf_q, cout_q;

   logic          accept;
   logic          run_step;
   logic          run_last;

   logic [W-1:0]  prod_sh;
   logic          fin_ovf, fin_cout, fin_zero;
   logic [M-1:0]  fin_mag;
   logic [N-1:0]  fin_c;

   // A new operation is accepted whenever the unit is not iterating,
   // which includes the single DONE cycle (back-to-back issue).
   assign accept   = start && (state_q != ST_RUN);
   // The counter runs M iterations; the edge that finds it at zero only
   // finalises, giving N edges from the start edge to done.
   assign run_step = (state_q == ST_RUN) && (cnt_q != '0);
   assign run_last = (state_q == ST_RUN) && (cnt_q == '0);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN:  if (cnt_q == '0) state_d = ST_DONE;
         ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Handshake outputs decoded from the current state.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         ST_RUN:  busy = 1'b1;
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   // Operand latching and one shift-add iteration per RUN cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         sign_q   <= 1'b0;
      end else if (accept) begin
         mcand_q  <= {{M{1'b0}}, a[M-1:0]};
         mplier_q <= b[M-1:0];
         acc_q    <= '0;
         cnt_q    <= CW'(M);
         sign_q   <= a[N-1] ^ b[N-1];
      end else if (run_step) begin
         if (mplier_q[0]) acc_q <= acc_q + mcand_q;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q - 1'b1;
      end
   end

   // Fraction alignment, overflow/saturation and sign packing of the product.
   always_comb begin
      prod_sh  = acc_q >> FRAC;
      fin_ovf  = |prod_sh[W-1:M];
      fin_cout = prod_sh[M];
      fin_mag  = (fin_ovf && (SAT != 0)) ? {M{1'b1}} : prod_sh[M-1:0];
      fin_zero = (fin_mag == '0);
      fin_c    = {(fin_zero ? 1'b0 : sign_q), fin_mag};
   end

   // Result registers, loaded on DONE entry and held until the next one.
   always_ff @(posedge clk) begin
      if (rst) begin
         c_q    <= '0;
         zero_q <= 1'b0;
         ovf_q  <= 1'b0;
         cout_q <= 1'b0;
      end else if (run_last) begin
         c_q    <= fin_c;
         zero_q <= fin_zero;
         ovf_q  <= fin_ovf;
         cout_q <= fin_cout;
      end
   end

   assign c        = c_q;
   assign zero     = zero_q;
   assign neg      = c_q[N-1];
   assign overflow = ovf_q;
   assign cout     = cout_q;

endmodule
`default_nettype wire
